// File: rtl/block_nest_checker.sv
// block_nest_checker: scans a space-separated ASCII stream and tracks the
// nesting of "begin"/"end" keywords. A keyword only counts once the space
// that ends it has been accepted. Unbalanced input latches a sticky error
// and parks the checker in ERR until reset.
module block_nest_checker #(
  parameter int DEPTH_W   = 8,
  parameter int CASE_SENS = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in,
  input  logic               in_valid,
  output logic               result,
  output logic [DEPTH_W-1:0] depth,
  output logic               err_under,
  output logic               err_over
);

  typedef enum logic [3:0] {
    IDLE, B1, B2, B3, B4, B5, E1, E2, E3, OTHER, ERR
  } state_t;

  localparam logic [DEPTH_W-1:0] DMAX = '1;

  state_t             state, state_n;
  logic [DEPTH_W-1:0] depth_n;
  logic               under_n, over_n, result_n;
  logic               sp;

  // Lowercase letter match; in case-insensitive mode the uppercase form
  // (lowercase minus 0x20) also matches.
  function automatic logic is_ch(input logic [7:0] c, input logic [7:0] lc);
    return (c == lc) || ((CASE_SENS == 0) && (c == (lc - 8'h20)));
  endfunction

  assign sp = (in == 8'h20);

  // Next-state, depth commit and sticky flags; everything holds when no
  // character is accepted.
  always_comb begin
    state_n = state;
    depth_n = depth;
    under_n = err_under;
    over_n  = err_over;
    if (in_valid) begin
      unique case (state)
        IDLE:  state_n = sp ? IDLE : is_ch(in, "b") ? B1 :
                         is_ch(in, "e") ? E1 : OTHER;
        B1:    state_n = sp ? IDLE : is_ch(in, "e") ? B2 : OTHER;
        B2:    state_n = sp ? IDLE : is_ch(in, "g") ? B3 : OTHER;
        B3:    state_n = sp ? IDLE : is_ch(in, "i") ? B4 : OTHER;
        B4:    state_n = sp ? IDLE : is_ch(in, "n") ? B5 : OTHER;
        E1:    state_n = sp ? IDLE : is_ch(in, "n") ? E2 : OTHER;
        E2:    state_n = sp ? IDLE : is_ch(in, "d") ? E3 : OTHER;
        B5: begin
          if (!sp) begin
            state_n = OTHER;
          end else if (depth != DMAX) begin
            depth_n = depth + 1'b1;
            state_n = IDLE;
          end else begin
            over_n  = 1'b1;
            state_n = ERR;
          end
        end
        E3: begin
          if (!sp) begin
            state_n = OTHER;
          end else if (depth != '0) begin
            depth_n = depth - 1'b1;
            state_n = IDLE;
          end else begin
            under_n = 1'b1;
            state_n = ERR;
          end
        end
        OTHER: state_n = sp ? IDLE : OTHER;
        ERR:   state_n = ERR;
        default: state_n = IDLE;
      endcase
    end
  end

  // Balance prediction: a pending "begin" is never balanced, a pending
  // "end" balances only if it would close the last open block.
  always_comb begin
    result_n = result;
    if (in_valid) begin
      unique case (state_n)
        ERR:     result_n = 1'b0;
        B5:      result_n = 1'b0;
        E3:      result_n = (depth_n == DEPTH_W'(1));
        default: result_n = (depth_n == '0);
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      depth     <= '0;
      result    <= 1'b1;
      err_under <= 1'b0;
      err_over  <= 1'b0;
    end else begin
      state     <= state_n;
      depth     <= depth_n;
      result    <= result_n;
      err_under <= under_n;
      err_over  <= over_n;
    end
  end

endmodule

// File: tb/tb_block_nest_checker.sv
// Scoreboard bench for block_nest_checker. Three instances cover the default
// configuration, a 2-bit depth counter and lowercase-only matching. Stimulus
// tasks push hand-computed expectations; a monitor pops one per falling edge.
module tb_block_nest_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in = 8'h00;
  logic       in_valid = 1'b0;

  logic       r0, r1, r2, u0, u1, u2, o0, o1, o2;
  logic [7:0] d0, d2;
  logic [1:0] d1;

  always #5 clk = ~clk;

  block_nest_checker #(.DEPTH_W(8), .CASE_SENS(0)) dut0 (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
    .result(r0), .depth(d0), .err_under(u0), .err_over(o0));
  block_nest_checker #(.DEPTH_W(2), .CASE_SENS(0)) dut1 (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
    .result(r1), .depth(d1), .err_under(u1), .err_over(o1));
  block_nest_checker #(.DEPTH_W(8), .CASE_SENS(1)) dut2 (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
    .result(r2), .depth(d2), .err_under(u2), .err_over(o2));

  typedef struct {
    int    sel;
    bit    r;
    int    d;
    bit    u;
    bit    o;
    string nm;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nerr = 0;

  localparam byte CH_1 = 8'h31;
  localparam byte CH_U = 8'h75;
  localparam byte CH_O = 8'h6f;

  task automatic push(input int sel, input bit r, input int d, input bit u,
                      input bit o, input string nm);
    exp_t e;
    e.sel = sel; e.r = r; e.d = d; e.u = u; e.o = o; e.nm = nm;
    q.push_back(e);
  endtask

  // Feed a string; rs/ds/fs give per-character result, depth digit and
  // flag ('0' none, 'u' under, 'o' over) after that character's edge.
  task automatic run(input int sel, input string s, input string rs,
                     input string ds, input string fs, input string nm);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      in = s[i];
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      push(sel, rs[i] == CH_1, int'(ds[i]) - 48, fs[i] == CH_U, fs[i] == CH_O,
           $sformatf("%s[%0d]", nm, i));
    end
  endtask

  task automatic hold(input int sel, input byte ch, input int n, input bit r,
                      input int d, input string nm);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in = ch;
      in_valid = 1'b0;
      @(posedge clk);
      #1 push(sel, r, d, 1'b0, 1'b0, $sformatf("%s[%0d]", nm, i));
    end
  endtask

  task automatic do_reset(input int sel, input string nm);
    @(negedge clk);
    reset = 1'b1;
    #1 push(sel, 1'b1, 0, 1'b0, 1'b0, nm);
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  // Reset raised between edges; checked before any further clock edge.
  task automatic mid_reset(input int sel, input string nm);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 push(sel, 1'b1, 0, 1'b0, 1'b0, nm);
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  // Monitor: compare the selected instance against the queue head.
  initial begin
    exp_t e;
    bit   ar, au, ao;
    int   ad;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        case (e.sel)
          0:       begin ar = r0; ad = int'(d0); au = u0; ao = o0; end
          1:       begin ar = r1; ad = int'(d1); au = u1; ao = o1; end
          default: begin ar = r2; ad = int'(d2); au = u2; ao = o2; end
        endcase
        nvec++;
        if (ar !== e.r || ad != e.d || au !== e.u || ao !== e.o) begin
          nerr++;
          $display("FAIL %s: got r=%0b d=%0d u=%0b o=%0b, want r=%0b d=%0d u=%0b o=%0b",
                   e.nm, ar, ad, au, ao, e.r, e.d, e.u, e.o);
        end
      end
    end
  end

  initial begin
    #1;
    push(0, 1'b1, 0, 1'b0, 1'b0, "por0");
    push(1, 1'b1, 0, 1'b0, 1'b0, "por1");
    push(2, 1'b1, 0, 1'b0, 1'b0, "por2");
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;

    run(0, "BeGiN x EnD ", "111100000011", "000001111110", "000000000000", "mixcase");
    do_reset(0, "rst_a");
    run(0, "begin begin end ", "1111000000000000", "0000011111122221",
        "0000000000000000", "nest2");
    do_reset(0, "rst_b");
    run(0, "end begin end ", "11000000000000", "00000000000000",
        "000uuuuuuuuuuu", "under");
    do_reset(0, "rst_c");
    run(0, "beginx endc ", "111101111011", "000000000000", "000000000000", "nonkw");

    do_reset(1, "rst_d");
    run(1, "begin begin begin begin ", "111100000000000000000000",
        "000001111112222223333333", "00000000000000000000000o", "over");
    do_reset(1, "rst_after_over");

    do_reset(2, "rst_e");
    run(2, "BEGIN ", "111111", "000000", "000000", "upper_cs");
    run(2, "be", "11", "00", "00", "pre_hold");
    hold(2, "b", 5, 1'b1, 0, "hold");
    run(2, "gin ", "1100", "0001", "0000", "post_hold");
    run(2, "beg", "000", "111", "000", "pre_mid");
    mid_reset(2, "mid_reset");
    run(2, "in ", "111", "000", "000", "after_mid");

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      nerr++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
